// File: rtl/ps2_pkg.sv
// Shared PS/2 host-link constants: FSM encoding, result codes, 50 MHz defaults.
// Optional retry build: define PS2_TX_RETRY_EN (see ps2_host_tx).
package ps2_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_REQ       = 3'd3;
    localparam logic [2:0] S_BITS      = 3'd4;
    localparam logic [2:0] S_ACK       = 3'd5;
    localparam logic [2:0] S_WAIT_IDLE = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    localparam logic [1:0] PS2_OK       = 2'b00;
    localparam logic [1:0] PS2_NAK      = 2'b01;
    localparam logic [1:0] PS2_TO_START = 2'b10;
    localparam logic [1:0] PS2_TO_PKT   = 2'b11;

    localparam int unsigned PS2_FRAME_BITS  = 11;
    localparam int unsigned PS2_INHIBIT_50M = 5000;
    localparam int unsigned PS2_START_TO_50M = 750000;
    localparam int unsigned PS2_PKT_TO_50M  = 100000;
    localparam int unsigned PS2_FILTER_LEN  = 8;

    // Index 0..7 data, 8 parity, 9 stop.
    function automatic logic frame_bit(input logic [8:0] payload,
                                       input logic [3:0] idx);
        return (idx >= 4'd9) ? 1'b1 : payload[idx];
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, agreement filter, fall strobe.
// Shared by the transmit and receive paths.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_line,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic          filt_q, filt_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], i_line};
        filt_d = filt_q;
        cnt_d  = '0;
        // Count consecutive disagreeing samples; flip on the last one.
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_line = filt_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter with ACK/NAK/timeout reporting.
// Define PS2_TX_RETRY_EN for one automatic resend on NAK or packet timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES        = PS2_INHIBIT_50M,
    parameter int unsigned START_TIMEOUT_CYCLES  = PS2_START_TO_50M,
    parameter int unsigned PACKET_TIMEOUT_CYCLES = PS2_PKT_TO_50M,
    parameter int unsigned FILTER_LEN            = PS2_FILTER_LEN
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iSend,
    input  logic [7:0] iData,
    input  logic       iPS2Clk,
    input  logic       iPS2Data,
    output logic       oPS2ClkDrive,
    output logic       oPS2DataDrive,
    output logic       oBusy,
    output logic       oRxInhibit,
    output logic       oDone,
    output logic [1:0] oError
);

    logic clk_line, clk_fall, dat_line, dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk    (Clock),
        .rst_n  (Reset),
        .i_line (iPS2Clk),
        .o_line (clk_line),
        .o_fall (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk    (Clock),
        .rst_n  (Reset),
        .i_line (iPS2Data),
        .o_line (dat_line),
        .o_fall (dat_fall_unused)
    );

    logic [2:0]  state_q, state_d;
    logic [8:0]  data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] timer_q, timer_d;
    logic        clk_drv_q, clk_drv_d;
    logic        dat_drv_q, dat_drv_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        nak_q, nak_d;
    logic        fin_v, do_retry;
    logic [1:0]  fin_err;
    logic        pkt_to;
`ifdef PS2_TX_RETRY_EN
    logic        retry_q, retry_d;
`endif

    assign pkt_to = (timer_q == PACKET_TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        clk_drv_d = clk_drv_q;
        dat_drv_d = dat_drv_q;
        done_d    = 1'b0;
        err_d     = err_q;
        nak_d     = nak_q;
        fin_v     = 1'b0;
        fin_err   = PS2_OK;
        do_retry  = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (iSend) begin
                    state_d   = S_INHIBIT;
                    data_d    = {~^iData, iData};
                    clk_drv_d = 1'b1;
                    dat_drv_d = 1'b0;
                    timer_d   = '0;
                    cnt_d     = '0;
                    nak_d     = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (timer_q == INHIBIT_CYCLES - 1) begin
                    state_d   = S_START;
                    dat_drv_d = 1'b1;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_START: begin
                state_d   = S_REQ;
                clk_drv_d = 1'b0;
            end
            S_REQ: begin
                // First device clock: the start bit is taken, place bit 0.
                if (clk_fall) begin
                    state_d   = S_BITS;
                    dat_drv_d = ~frame_bit(data_q, 4'd0);
                    cnt_d     = 4'd1;
                    timer_d   = '0;
                end else if (timer_q == START_TIMEOUT_CYCLES) begin
                    fin_v   = 1'b1;
                    fin_err = PS2_TO_START;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            S_BITS: begin
                timer_d = timer_q + 32'd1;
                if (pkt_to) begin
                    fin_v   = 1'b1;
                    fin_err = PS2_TO_PKT;
                end else if (clk_fall) begin
                    dat_drv_d = ~frame_bit(data_q, cnt_q);
                    if (cnt_q == 4'(PS2_FRAME_BITS - 2)) begin
                        state_d = S_ACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_ACK: begin
                timer_d = timer_q + 32'd1;
                if (pkt_to) begin
                    fin_v   = 1'b1;
                    fin_err = PS2_TO_PKT;
                end else if (clk_fall) begin
                    nak_d   = dat_line;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                timer_d = timer_q + 32'd1;
                if (pkt_to) begin
                    fin_v   = 1'b1;
                    fin_err = PS2_TO_PKT;
                end else if (clk_line && dat_line) begin
                    fin_v   = 1'b1;
                    fin_err = nak_q ? PS2_NAK : PS2_OK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PS2_TX_RETRY_EN
        do_retry = !retry_q && fin_err != PS2_TO_START && fin_err != PS2_OK;
`endif
        if (fin_v && do_retry) begin
            state_d   = S_INHIBIT;
            clk_drv_d = 1'b1;
            dat_drv_d = 1'b0;
            timer_d   = '0;
            cnt_d     = '0;
            nak_d     = 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_d   = 1'b1;
`endif
        end else if (fin_v) begin
            state_d   = S_DONE;
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
            done_d    = 1'b1;
            err_d     = fin_err;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            clk_drv_q <= 1'b0;
            dat_drv_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= PS2_OK;
            nak_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            clk_drv_q <= clk_drv_d;
            dat_drv_q <= dat_drv_d;
            done_q    <= done_d;
            err_q     <= err_d;
            nak_q     <= nak_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign oPS2ClkDrive  = clk_drv_q;
    assign oPS2DataDrive = dat_drv_q;
    assign oBusy         = (state_q != S_IDLE);
    assign oRxInhibit    = oBusy;
    assign oDone         = done_q;
    assign oError        = err_q;

endmodule
